game_text_buf: RTL
==================

# game_text_buf

Parametrised, writable character buffer for the game's on-screen text layer. It replaces fixed per-screen text ROMs with one RAM-backed grid of COLS×ROWS character codes. A cursor-driven write port feeds it, and a hardware clear engine resets the grid. The renderer reads it through the same `char_xy` → `char_code` lookup, with 1-cycle registered latency.

## Interface
- COLS, 16, characters per row (≥2)
- ROWS, 8, rows (≥2)
- CODE_W, 7, character code width
- NL_CODE, 7'h7F, write code treated as newline (never stored)
- Derived: CW = $clog2(COLS), RW = $clog2(ROWS)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- char_xy  in  RW+CW  read address {row, col}, row in upper bits
- char_code  out  CODE_W  registered read data
- wr_valid  in  1  write request
- wr_code  in  CODE_W  character or NL_CODE
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- clr  in  1  single-cycle clear request
- busy  out  1  clear/scroll engine active
- cursor_x  out  CW  next write column
- cursor_y  out  RW  next write row (display row)

## Operation
- Storage is COLS*ROWS × CODE_W RAM and is not reset. The clear engine fills it with vga_pkg SPACE.
- FSM states: IDLE, CLEAR, LINECLR (LINECLR exists only with the macro).
- Reset puts the FSM in CLEAR, with cursor = (0,0) and top_row = 0.
- CLEAR writes SPACE to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE.
- wr_ready = (state==IDLE) & ~clr. busy = (state!=IDLE).
- Printable write (wr_code≠NL_CODE):
  - Stores wr_code at physical cell (phys_row(cursor_y), cursor_x).
  - cursor_x increments. At cursor_x==COLS-1, cursor_x goes to 0 and the cursor advances a line.
- NL_CODE write: nothing is stored. cursor_x goes to 0 and the cursor advances a line.
- Advance line:
  - If cursor_y<ROWS-1, cursor_y increments.
  - Otherwise, see Configuration.
- clr has top priority in any state:
  - The next state is CLEAR, the cursor goes to (0,0) and top_row to 0.
  - A running CLEAR/LINECLR restarts from address 0.
  - A same-cycle write is not accepted.
- Read path:
  - phys_row = (row + top_row) mod ROWS, computed by add and conditional subtract, so non-power-of-two ROWS is allowed.
  - If col ≥ COLS or row ≥ ROWS, char_code returns SPACE.
  - Reads are allowed in every state and return current RAM contents.

## Timing
- Reset values: char_code = SPACE, wr_ready = 0, busy = 1, cursor_x = 0, cursor_y = 0.
- Read latency is 1 cycle: char_xy sampled at edge N appears on char_code after edge N.
- Read-during-write to the same cell returns the old data. The new data is visible to a read sampled at edge N+1.
- A write accepted at edge N updates the cursor outputs after edge N.
- Initial clear and clr clear take exactly COLS*ROWS cycles in CLEAR.
  - busy falls, and wr_ready rises, on the edge after the last cell is written.
  - Default parameters: 128 cycles.
- A clr pulse during CLEAR makes the total clear take COLS*ROWS cycles from that pulse.
- LINECLR takes exactly COLS cycles, with wr_ready low throughout.
- Back-to-back writes are sustained at 1 per cycle in IDLE.

## Configuration
- TEXT_BUF_SCROLL_EN defined, advance line from cursor_y==ROWS-1:
  - cursor_y stays at ROWS-1 and top_row increments mod ROWS.
  - The FSM enters LINECLR and writes SPACE to the COLS cells of the physical row that is now the last display row.
  - The display scrolls up by one line with no data copying.
- TEXT_BUF_SCROLL_EN undefined:
  - cursor_y wraps to 0 and top_row stays 0.
  - Old text is overwritten in place, with no clear.
  - LINECLR and the top_row adder are not built (phys_row = row).

## Test plan
- Reset release: busy=1 and wr_ready=0 for exactly 128 cycles. After that, every char_xy 8'h00..8'h7F reads SPACE, and 8'h0F with COLS=12 reads SPACE.
- Write codes 1,2,3 back-to-back:
  - char_xy 8'h00/01/02 read 1/2/3 one cycle after address.
  - Cursor ends at (3,0).
  - A same-cycle read of cell 8'h00 while writing it returns SPACE.
- Write 16 printable codes: cursor goes (15,0)→(0,1). Then NL_CODE: cursor (0,2), and 8'h20 still reads SPACE.
- Fill 8 rows with 128 writes, row r = code r+1:
  - Without macro: cursor (0,0). The next write replaces 8'h00 only, and 8'h10 still reads 2.
  - With macro: busy for 16 cycles. Row 0 reads 2, row 7 reads SPACE, cursor (0,7).
- clr asserted together with wr_valid mid-CLEAR and in IDLE: write dropped, cursor (0,0), busy for 128 cycles from the clr edge, all cells SPACE.
- rst_n asserted mid-LINECLR: outputs return to reset values immediately (asynchronous), and a full 128-cycle clear follows release.

Source files
------------

// File: rtl/game_text_buf.sv
// On-screen text layer: COLS x ROWS RAM-backed character grid with a cursor write port,
// a hardware clear engine and a 1-cycle registered read port. Define TEXT_BUF_SCROLL_EN to scroll instead of wrap.
package vga_pkg;
  localparam logic [6:0] SPACE = 7'h20;
endpackage

module game_text_buf #(
  parameter int                 COLS    = 16,
  parameter int                 ROWS    = 8,
  parameter int                 CODE_W  = 7,
  parameter logic [CODE_W-1:0]  NL_CODE = CODE_W'(7'h7F),
  localparam int                CW      = $clog2(COLS),
  localparam int                RW      = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RW+CW-1:0]  char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  input  logic              clr,
  output logic              busy,
  output logic [CW-1:0]     cursor_x,
  output logic [RW-1:0]     cursor_y
);

  localparam int                DEPTH     = COLS * ROWS;
  localparam int                AW        = $clog2(DEPTH);
  localparam logic [CODE_W-1:0] SPACE     = CODE_W'(vga_pkg::SPACE);
  localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     LAST_LCOL = AW'(COLS - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);

`ifdef TEXT_BUF_SCROLL_EN
  typedef enum logic [1:0] {IDLE, CLEAR, LINECLR} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif

  state_t              state;
  logic [AW-1:0]       cnt;
  logic [CODE_W-1:0]   mem [DEPTH];

  logic [RW-1:0]       rd_row, rd_prow, cur_prow;
  logic [CW-1:0]       rd_col;
  logic                col_oob, row_oob, rd_oob;
  logic [AW-1:0]       rd_addr;

  logic                wr_accept;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // Display row -> physical row. Scrolling rotates the mapping instead of moving data.
`ifdef TEXT_BUF_SCROLL_EN
  logic [RW-1:0] top_row;

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] row, input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    return sum[RW-1:0];
  endfunction

  always_comb begin
    cur_prow = phys_row(cursor_y, top_row);
    rd_prow  = phys_row(rd_row, top_row);
  end
`else
  always_comb begin
    cur_prow = cursor_y;
    rd_prow  = rd_row;
  end
`endif

  always_comb begin
    rd_row = char_xy[RW+CW-1:CW];
    rd_col = char_xy[CW-1:0];
  end

  // Out-of-range checks exist only when the field can encode values past the grid.
  if (COLS == (1 << CW)) begin : g_col_full
    assign col_oob = 1'b0;
  end else begin : g_col_part
    assign col_oob = (rd_col > LAST_COL);
  end

  if (ROWS == (1 << RW)) begin : g_row_full
    assign row_oob = 1'b0;
  end else begin : g_row_part
    assign row_oob = (rd_row > LAST_ROW);
  end

  assign rd_oob  = col_oob | row_oob;
  assign rd_addr = rd_oob ? '0 : cell_addr(rd_prow, rd_col);

  // NOTE: non-blocking read of mem alongside a same-edge write returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_code <= SPACE;
    else        char_code <= rd_oob ? SPACE : mem[rd_addr];
  end

  assign wr_ready  = (state == IDLE) & ~clr;
  assign wr_accept = wr_valid & wr_ready;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cell_addr(cur_prow, cursor_x);
    mem_wdata = SPACE;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt;
      end
`ifdef TEXT_BUF_SCROLL_EN
      LINECLR: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(cur_prow, CW'(cnt));
      end
`endif
      default: begin
        if (wr_accept && (wr_code != NL_CODE)) begin
          mem_we    = 1'b1;
          mem_wdata = wr_code;
        end
      end
    endcase
  end

  // NOTE: the character RAM has no reset; the clear engine initialises it after reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      busy     <= 1'b1;
      cnt      <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
`ifdef TEXT_BUF_SCROLL_EN
      top_row  <= '0;
`endif
    end else if (clr) begin
      state    <= CLEAR;
      busy     <= 1'b1;
      cnt      <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
`ifdef TEXT_BUF_SCROLL_EN
      top_row  <= '0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef TEXT_BUF_SCROLL_EN
        LINECLR: begin
          if (cnt == LAST_LCOL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: begin
          if (wr_accept) begin
            if ((wr_code != NL_CODE) && (cursor_x != LAST_COL)) begin
              cursor_x <= cursor_x + 1'b1;
            end else begin
              cursor_x <= '0;
              if (cursor_y != LAST_ROW) begin
                cursor_y <= cursor_y + 1'b1;
              end else begin
`ifdef TEXT_BUF_SCROLL_EN
                // Bottom line reached: rotate the view and blank the recycled row.
                top_row <= (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
                state   <= LINECLR;
                busy    <= 1'b1;
                cnt     <= '0;
`else
                cursor_y <= '0;
`endif
              end
            end
          end
        end
      endcase
    end
  end

endmodule
